sccb_target_responder: RTL and testbench

SCCB/I2C target (slave) that answers the camera-init I2C master. It emulates an OV7670-style register interface: it decodes START, device address, register index and data bytes, and issues register write strobes and reads over a simple register port. It serves as the camera model in the camera-control testbench and as a synthesizable loopback target for bring-up on the board's spare I2C pins.

---
 rtl/sccb_target_pkg.sv | 28 ++
 rtl/sccb_line_sync.sv | 38 +++
 rtl/sccb_target_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_sccb_target_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_target_pkg.sv
// sccb_target_pkg
// Shared types and constants for the SCCB/I2C target responder.
//   state_t  : protocol state of the target FSM
//   ACK/NACK : bus level of the acknowledge bit (also the sda_oen value that
//              produces it, since sda_oen = 0 pulls the line low)
//   BYTE_BITS: bits per SCCB byte
//   RD_LOAD  : bit-counter marker meaning "read byte still to be fetched"
package sccb_target_pkg;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      REG,
      REG_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK,
      IGNORE
   } state_t;

   localparam logic ACK = 1'b0;
   localparam logic NACK = 1'b1;
   localparam int BYTE_BITS = 8;
   localparam logic [3:0] RD_LOAD = 4'hF;

endpackage

// File: rtl/sccb_line_sync.sv
// sccb_line_sync
// Synchronizes one asynchronous pad input into sys_clk and flags its edges.
// The line idles high, so every flop resets to 1 to avoid a phantom edge
// when reset is released.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   pad                : raw pad input
//   level              : synchronized level
//   rise, fall         : single-cycle edge flags on the synchronized level
module sccb_line_sync #(
   parameter int STAGES = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pad};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = sync_q[STAGES-1] & ~hist_q;
   assign fall  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/sccb_target_responder.sv
// sccb_target_responder
// SCCB/I2C target emulating an OV7670-style register file. Decodes START,
// device address, register index and data bytes; issues write strobes and
// serves reads through a simple register port.
// Optional read path: define SCCB_TARGET_READ_EN. Without it an address with
// R/W = 1 is NACKed and reg_rd_data is ignored.
// Ports:
//   sys_clk, sys_rst_n : system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i       : asynchronous pad inputs
//   sda_oen            : 1 = release SDA, 0 = pull low (open-drain)
//   reg_wr_stb/addr/data : one-cycle write strobe with index and data
//   reg_rd_addr        : current register pointer
//   reg_rd_data        : combinational read data at reg_rd_addr
//   busy               : high from a matching address until STOP
//   state_dbg          : current FSM state (state_t encoding)
// Handshake: there is no valid/ready pair; reg_wr_stb is a pure one-cycle
// qualifier for reg_wr_addr/reg_wr_data, and reg_rd_data must be valid in
// the same cycle reg_rd_addr is presented.
module sccb_target_responder
   import sccb_target_pkg::*;
#(
   parameter logic [6:0] DEVICE_ADDR = 7'h21,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oen,
   output logic       reg_wr_stb,
   output logic [7:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic [7:0] reg_rd_addr,
   input  logic [7:0] reg_rd_data,
   output logic       busy,
   output logic [3:0] state_dbg
);

`ifdef SCCB_TARGET_READ_EN
   localparam logic READ_EN = 1'b1;
`else
   localparam logic READ_EN = 1'b0;
   logic unused_rd_data;
   assign unused_rd_data = ^reg_rd_data;
`endif

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   sccb_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pad(scl_i),
      .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );

   sccb_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pad(sda_i),
      .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   // SDA edges while SCL is high are bus conditions, never data.
   logic start_evt, stop_evt;
   assign start_evt = sda_fall & scl_lvl;
   assign stop_evt  = sda_rise & scl_lvl;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] wr_addr_q, wr_addr_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       oen_q, oen_d;
   logic       stb_q, stb_d;
   logic       busy_q, busy_d;
   logic [7:0] byte_in;
   logic       last_bit;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         shift_q   <= 8'h00;
         ptr_q     <= 8'h00;
         wr_addr_q <= 8'h00;
         wr_data_q <= 8'h00;
         oen_q     <= 1'b1;
         stb_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         oen_q     <= oen_d;
         stb_q     <= stb_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      oen_d     = oen_q;
      stb_d     = 1'b0;
      busy_d    = busy_q;
      byte_in   = {shift_q[6:0], sda_lvl};
      last_bit  = (cnt_q == 4'(BYTE_BITS - 1));

      if (stop_evt) begin
         // STOP wins over any sample in the same cycle; a partial byte is lost.
         state_d = IDLE;
         cnt_d   = 4'd0;
         oen_d   = 1'b1;
         busy_d  = 1'b0;
      end else if (start_evt) begin
         // START or repeated START; the register pointer is preserved.
         state_d = ADDR;
         cnt_d   = 4'd0;
         oen_d   = 1'b1;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 4'd1;
               if (last_bit) begin
                  cnt_d = 4'd0;
                  if (byte_in[7:1] == DEVICE_ADDR && (READ_EN || !byte_in[0])) begin
                     state_d = ADDR_ACK;
                     busy_d  = 1'b1;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            REG: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 4'd1;
               if (last_bit) begin
                  cnt_d   = 4'd0;
                  ptr_d   = byte_in;
                  state_d = REG_ACK;
               end
            end
            WDATA: if (scl_rise) begin
               shift_d = byte_in;
               cnt_d   = cnt_q + 4'd1;
               if (last_bit) begin
                  cnt_d     = 4'd0;
                  stb_d     = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = byte_in;
                  state_d   = WDATA_ACK;
               end
            end
            // Acknowledge slot: cnt 0 -> pull low on the first SCL fall,
            // cnt 1 -> release on the second fall and move on.
            ADDR_ACK, REG_ACK, WDATA_ACK: if (scl_fall) begin
               if (cnt_q == 4'd0) begin
                  oen_d = ACK;
                  cnt_d = 4'd1;
               end else begin
                  oen_d = NACK;
                  cnt_d = 4'd0;
                  if (state_q == ADDR_ACK) begin
                     state_d = REG;
`ifdef SCCB_TARGET_READ_EN
                     // shift_q still holds the address byte; bit 0 is R/W.
                     if (shift_q[0]) begin
                        state_d = RDATA;
                        cnt_d   = RD_LOAD;
                     end
`endif
                  end else if (state_q == REG_ACK) begin
                     state_d = WDATA;
                  end else begin
                     ptr_d   = ptr_q + 8'd1;
                     state_d = WDATA;
                  end
               end
            end
`ifdef SCCB_TARGET_READ_EN
            // Byte is fetched one cycle after entry, while SCL is still low,
            // and bit 7 goes out immediately; later bits go out on SCL falls.
            RDATA: begin
               if (cnt_q == RD_LOAD) begin
                  shift_d = reg_rd_data;
                  oen_d   = reg_rd_data[7];
                  cnt_d   = 4'd0;
               end else if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'(BYTE_BITS)) begin
                     oen_d   = 1'b1;
                     cnt_d   = 4'd0;
                     state_d = RDATA_ACK;
                  end else begin
                     shift_d = {shift_q[6:0], 1'b0};
                     oen_d   = shift_q[6];
                  end
               end
            end
            // Master bit is sampled on the rise; the decision waits for the
            // fall so SDA never changes while SCL is high.
            RDATA_ACK: begin
               if (scl_rise) begin
                  shift_d[0] = sda_lvl;
                  cnt_d      = 4'd1;
               end else if (scl_fall && cnt_q == 4'd1) begin
                  cnt_d = 4'd0;
                  if (shift_q[0] == ACK) begin
                     ptr_d   = ptr_q + 8'd1;
                     state_d = RDATA;
                     cnt_d   = RD_LOAD;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign sda_oen     = oen_q;
   assign reg_wr_stb  = stb_q;
   assign reg_wr_addr = wr_addr_q;
   assign reg_wr_data = wr_data_q;
   assign reg_rd_addr = ptr_q;
   assign busy        = busy_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_sccb_target_responder.sv
module tb_sccb_target_responder;
   import sccb_target_pkg::*;

   localparam int TQ = 8;   // SDA setup before SCL rise (sys_clk cycles)
   localparam int TH = 16;  // SCL high time
   localparam int TD = 4;   // SCL low hold after fall

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       scl_i = 1'b1;
   logic       sda_m = 1'b1;
   logic       sda_i;
   logic       sda_oen;
   logic       reg_wr_stb;
   logic [7:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
   logic       busy;
   logic [3:0] state_dbg;

   int vectors = 0;
   int miscompares = 0;

   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int          stb_long_cnt = 0;
   logic        stb_prev = 1'b0;

   always #5 sys_clk = ~sys_clk;

   // Open-drain bus: master and target wired-AND.
   assign sda_i = sda_m & sda_oen;

   // Register file model for reads.
   always_comb begin
      case (reg_rd_addr)
         8'h0A:   reg_rd_data = 8'h76;
         8'h0B:   reg_rd_data = 8'h55;
         default: reg_rd_data = 8'h00;
      endcase
   end

   sccb_target_responder dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl_i(scl_i), .sda_i(sda_i),
      .sda_oen(sda_oen), .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data), .reg_rd_addr(reg_rd_addr),
      .reg_rd_data(reg_rd_data), .busy(busy), .state_dbg(state_dbg)
   );

   // Strobe capture: every strobe cycle is recorded with its payload.
   always @(negedge sys_clk) begin
      if (reg_wr_stb) got_q.push_back({reg_wr_addr, reg_wr_data});
      if (reg_wr_stb && stb_prev) stb_long_cnt = stb_long_cnt + 1;
      stb_prev = reg_wr_stb;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1; scl_i = 1'b1; tick(TQ);
      sda_m = 1'b0; tick(TQ);
      scl_i = 1'b0; tick(TD);
   endtask

   task automatic bus_rstart();
      sda_m = 1'b1; tick(TQ);
      scl_i = 1'b1; tick(TQ);
      sda_m = 1'b0; tick(TQ);
      scl_i = 1'b0; tick(TD);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; tick(TQ);
      scl_i = 1'b1; tick(TQ);
      sda_m = 1'b1; tick(TQ);
   endtask

   task automatic bus_bit(input logic b, output logic s);
      sda_m = b; tick(TQ);
      scl_i = 1'b1; tick(TH / 2);
      s = sda_i; tick(TH / 2);
      scl_i = 1'b0; tick(TD);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
      bus_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, s);
         d[i] = s;
      end
      bus_bit(mack, s);
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0; tick(3);
      sys_rst_n = 1'b1; tick(3);
      vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL reset_oen: got %b want 1", sda_oen); end
      vectors++; if (reg_wr_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %b want 0", reg_wr_stb); end
      vectors++; if (reg_wr_addr !== 8'h00 || reg_wr_data !== 8'h00) begin miscompares++; $display("FAIL reset_wr: got %h/%h want 00/00", reg_wr_addr, reg_wr_data); end
      vectors++; if (reg_rd_addr !== 8'h00) begin miscompares++; $display("FAIL reset_rd_addr: got %h want 00", reg_rd_addr); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE); end
   endtask

   task automatic test_write_single();
      logic ack;
      int   base = got_q.size();
      exp_q.delete();
      exp_q.push_back({8'h12, 8'h80});
      bus_start();
      write_byte(8'h42, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL single_ack_addr: got %b want 0", ack); end
      write_byte(8'h12, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL single_ack_reg: got %b want 0", ack); end
      write_byte(8'h80, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL single_ack_data: got %b want 0", ack); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_high: got %b want 1", busy); end
      bus_stop();
      tick(4);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_low: got %b want 0", busy); end
      vectors++; if (got_q.size() - base !== exp_q.size()) begin miscompares++; $display("FAIL single_stb_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
         vectors++; if (got_q[base + i] !== exp_q[i]) begin miscompares++; $display("FAIL single_stb_%0d: got %h want %h", i, got_q[base + i], exp_q[i]); end
      end
      vectors++; if (reg_rd_addr !== 8'h13) begin miscompares++; $display("FAIL single_ptr: got %h want 13", reg_rd_addr); end
   endtask

   task automatic test_addr_mismatch();
      logic ack;
      int   base = got_q.size();
      bus_start();
      write_byte(8'h50, ack);
      vectors++; if (ack !== NACK) begin miscompares++; $display("FAIL mismatch_nack: got %b want 1", ack); end
      vectors++; if (state_dbg !== IGNORE) begin miscompares++; $display("FAIL mismatch_state: got %0d want %0d", state_dbg, IGNORE); end
      write_byte(8'h11, ack);
      vectors++; if (ack !== NACK || busy !== 1'b0) begin miscompares++; $display("FAIL mismatch_ignored: got ack %b busy %b want 1 0", ack, busy); end
      bus_rstart();
      write_byte(8'h42, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL mismatch_restart_ack: got %b want 0", ack); end
      write_byte(8'h33, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL mismatch_reg_ack: got %b want 0", ack); end
      bus_stop();
      tick(4);
      vectors++; if (got_q.size() !== base) begin miscompares++; $display("FAIL mismatch_no_stb: got %0d want %0d", got_q.size(), base); end
      vectors++; if (reg_rd_addr !== 8'h33) begin miscompares++; $display("FAIL mismatch_ptr: got %h want 33", reg_rd_addr); end
   endtask

   task automatic test_burst_wrap();
      logic       ack;
      logic [7:0] data[3] = '{8'hA1, 8'hA2, 8'hA3};
      int         base = got_q.size();
      int         long_base = stb_long_cnt;
      exp_q.delete();
      exp_q.push_back({8'hFE, 8'hA1});
      exp_q.push_back({8'hFF, 8'hA2});
      exp_q.push_back({8'h00, 8'hA3});
      bus_start();
      write_byte(8'h42, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL burst_ack_addr: got %b want 0", ack); end
      write_byte(8'hFE, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL burst_ack_reg: got %b want 0", ack); end
      for (int i = 0; i < 3; i++) begin
         write_byte(data[i], ack);
         vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL burst_ack_data%0d: got %b want 0", i, ack); end
      end
      bus_stop();
      tick(4);
      vectors++; if (got_q.size() - base !== exp_q.size()) begin miscompares++; $display("FAIL burst_stb_count: got %0d want %0d", got_q.size() - base, exp_q.size()); end
      for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
         vectors++; if (got_q[base + i] !== exp_q[i]) begin miscompares++; $display("FAIL burst_stb_%0d: got %h want %h", i, got_q[base + i], exp_q[i]); end
      end
      vectors++; if (stb_long_cnt !== long_base) begin miscompares++; $display("FAIL burst_stb_width: got %0d long strobes want 0", stb_long_cnt - long_base); end
      vectors++; if (reg_rd_addr !== 8'h01) begin miscompares++; $display("FAIL burst_ptr_wrap: got %h want 01", reg_rd_addr); end
   endtask

`ifdef SCCB_TARGET_READ_EN
   task automatic test_read();
      logic       ack;
      logic [7:0] d;
      int         base = got_q.size();
      bus_start();
      write_byte(8'h42, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL read_ack_waddr: got %b want 0", ack); end
      write_byte(8'h0A, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL read_ack_reg: got %b want 0", ack); end
      bus_rstart();
      write_byte(8'h43, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL read_ack_raddr: got %b want 0", ack); end
      read_byte(ACK, d);
      vectors++; if (d !== 8'h76) begin miscompares++; $display("FAIL read_byte0: got %h want 76", d); end
      read_byte(NACK, d);
      vectors++; if (d !== 8'h55) begin miscompares++; $display("FAIL read_byte1: got %h want 55", d); end
      tick(2);
      vectors++; if (state_dbg !== IGNORE || sda_oen !== 1'b1) begin miscompares++; $display("FAIL read_release: got state %0d oen %b want %0d 1", state_dbg, sda_oen, IGNORE); end
      vectors++; if (reg_rd_addr !== 8'h0B) begin miscompares++; $display("FAIL read_ptr: got %h want 0B", reg_rd_addr); end
      bus_stop();
      tick(4);
      vectors++; if (got_q.size() !== base) begin miscompares++; $display("FAIL read_no_stb: got %0d want %0d", got_q.size(), base); end
   endtask
`else
   task automatic test_read_disabled();
      logic ack;
      bus_start();
      write_byte(8'h43, ack);
      vectors++; if (ack !== NACK) begin miscompares++; $display("FAIL rd_off_nack: got %b want 1", ack); end
      vectors++; if (state_dbg !== IGNORE || busy !== 1'b0) begin miscompares++; $display("FAIL rd_off_state: got state %0d busy %b want %0d 0", state_dbg, busy, IGNORE); end
      bus_stop();
      tick(4);
      vectors++; if (state_dbg !== IDLE) begin miscompares++; $display("FAIL rd_off_idle: got %0d want %0d", state_dbg, IDLE); end
   endtask
`endif

   task automatic test_stop_mid_byte();
      logic ack, s;
      logic [4:0] part = 5'b10110;
      int   base = got_q.size();
      bus_start();
      write_byte(8'h42, ack);
      write_byte(8'h20, ack);
      vectors++; if (ack !== ACK) begin miscompares++; $display("FAIL midstop_reg_ack: got %b want 0", ack); end
      for (int i = 4; i >= 0; i--) bus_bit(part[i], s);
      bus_stop();
      tick(4);
      vectors++; if (state_dbg !== IDLE || sda_oen !== 1'b1) begin miscompares++; $display("FAIL midstop_idle: got state %0d oen %b want %0d 1", state_dbg, sda_oen, IDLE); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midstop_busy: got %b want 0", busy); end
      vectors++; if (got_q.size() !== base) begin miscompares++; $display("FAIL midstop_no_stb: got %0d want %0d", got_q.size(), base); end
      vectors++; if (reg_wr_addr !== 8'h00 || reg_wr_data !== 8'hA3) begin miscompares++; $display("FAIL midstop_wr_hold: got %h/%h want 00/A3", reg_wr_addr, reg_wr_data); end
      vectors++; if (reg_rd_addr !== 8'h20) begin miscompares++; $display("FAIL midstop_ptr: got %h want 20", reg_rd_addr); end
   endtask

   task automatic test_reset_mid_ack();
      logic s;
      logic [7:0] a = 8'h42;
      bus_start();
      for (int i = 7; i >= 0; i--) bus_bit(a[i], s);
      vectors++; if (sda_oen !== 1'b0 || state_dbg !== ADDR_ACK) begin miscompares++; $display("FAIL rstack_driving: got oen %b state %0d want 0 %0d", sda_oen, state_dbg, ADDR_ACK); end
      sys_rst_n = 1'b0;
      #1;
      vectors++; if (sda_oen !== 1'b1) begin miscompares++; $display("FAIL rstack_oen_async: got %b want 1", sda_oen); end
      vectors++; if (state_dbg !== IDLE || busy !== 1'b0 || reg_wr_stb !== 1'b0) begin miscompares++; $display("FAIL rstack_ctrl: got state %0d busy %b stb %b want %0d 0 0", state_dbg, busy, reg_wr_stb, IDLE); end
      vectors++; if (reg_wr_addr !== 8'h00 || reg_wr_data !== 8'h00 || reg_rd_addr !== 8'h00) begin miscompares++; $display("FAIL rstack_regs: got %h/%h/%h want 00/00/00", reg_wr_addr, reg_wr_data, reg_rd_addr); end
      tick(2);
      sys_rst_n = 1'b1;
      scl_i = 1'b1; sda_m = 1'b1;
      tick(TQ);
      vectors++; if (state_dbg !== IDLE || sda_oen !== 1'b1) begin miscompares++; $display("FAIL rstack_after: got state %0d oen %b want %0d 1", state_dbg, sda_oen, IDLE); end
   endtask

   initial begin
      test_reset();
      test_write_single();
      test_addr_mismatch();
      test_burst_wrap();
`ifdef SCCB_TARGET_READ_EN
      test_read();
`else
      test_read_disabled();
`endif
      test_stop_mid_byte();
      test_reset_mid_ack();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
